// File: rtl/cond_unit_pipe_pkg.sv
// Shared constants for the execute-stage conditional unit: condition codes,
// NZCV bit positions and FlagW bit meanings.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_pipe_if.sv
// Execute-stage instruction bundle into the conditional unit and the gated
// write strobes / flag state coming back out.
interface cond_unit_pipe_if;
  logic       valid;
  logic       stall;
  logic       flush;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [1:0] FlagW;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;
  logic       CarryIn;

  modport master (
    output valid, stall, flush, PCS, RegW, MemW, NoWrite, FlagW, Cond, ALUFlags,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, CarryIn
  );

  modport slave (
    input  valid, stall, flush, PCS, RegW, MemW, NoWrite, FlagW, Cond, ALUFlags,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, CarryIn
  );
endinterface

// File: rtl/cond_unit_pipe_cond_check.sv
// Combinational ARM condition evaluation of a 4-bit Cond field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage conditional unit: NZCV register, write gating with stall/flush,
// optional registered strobes and saturating commit/fail counters.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter bit         REG_OUT  = 1'b0,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  cond_unit_pipe_if.slave  bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_ONE;
  endfunction

  logic [3:0] flags_q;
  logic       cond_ex;
  logic       go;
  logic       pcsrc_p0, regwrite_p0, memwrite_p0;

  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign go          = bus.valid & ~bus.stall & ~bus.flush;
  assign pcsrc_p0    = go & cond_ex & bus.PCS;
  assign regwrite_p0 = go & cond_ex & bus.RegW & ~bus.NoWrite;
  assign memwrite_p0 = go & cond_ex & bus.MemW;

  // Flags commit at the edge; the next instruction sees them one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RST;
    end else if (go && cond_ex) begin
      if (bus.FlagW[FLAGW_NZ]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (bus.FlagW[FLAGW_CV]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      instr_cnt <= '0;
      fail_cnt  <= '0;
    end else if (go) begin
      instr_cnt <= sat_inc(instr_cnt);
      if (!cond_ex) fail_cnt <= sat_inc(fail_cnt);
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic pcsrc_p1, regwrite_p1, memwrite_p1;

      // p0 -> p1: strobes delayed one cycle toward the hazard unit.
      always_ff @(posedge clk) begin
        if (reset) begin
          pcsrc_p1    <= 1'b0;
          regwrite_p1 <= 1'b0;
          memwrite_p1 <= 1'b0;
        end else begin
          pcsrc_p1    <= pcsrc_p0;
          regwrite_p1 <= regwrite_p0;
          memwrite_p1 <= memwrite_p0;
        end
      end

      assign bus.PCSrc    = pcsrc_p1;
      assign bus.RegWrite = regwrite_p1;
      assign bus.MemWrite = memwrite_p1;
    end else begin : g_comb_out
      assign bus.PCSrc    = pcsrc_p0;
      assign bus.RegWrite = regwrite_p0;
      assign bus.MemWrite = memwrite_p0;
    end
  endgenerate

  assign bus.CondEx  = cond_ex;
  assign bus.Flags   = flags_q;
  assign bus.CarryIn = flags_q[FLAG_C];

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed bench: a combinational-output 4-bit-counter instance and a
// registered-output 16-bit-counter instance driven with identical stimulus.
module tb_cond_unit_pipe;

  logic clk;
  logic reset;
  logic cnt_clr;
  logic       v_valid, v_stall, v_flush, v_pcs, v_regw, v_memw, v_nowrite;
  logic [1:0] v_flagw;
  logic [3:0] v_cond, v_aluflags;
  logic [3:0]  icnt_a, fcnt_a;
  logic [15:0] icnt_b, fcnt_b;

  int n_chk;
  int n_fail;

  cond_unit_pipe_if ifa ();
  cond_unit_pipe_if ifb ();

  assign ifa.valid = v_valid;    assign ifb.valid = v_valid;
  assign ifa.stall = v_stall;    assign ifb.stall = v_stall;
  assign ifa.flush = v_flush;    assign ifb.flush = v_flush;
  assign ifa.PCS = v_pcs;        assign ifb.PCS = v_pcs;
  assign ifa.RegW = v_regw;      assign ifb.RegW = v_regw;
  assign ifa.MemW = v_memw;      assign ifb.MemW = v_memw;
  assign ifa.NoWrite = v_nowrite; assign ifb.NoWrite = v_nowrite;
  assign ifa.FlagW = v_flagw;    assign ifb.FlagW = v_flagw;
  assign ifa.Cond = v_cond;      assign ifb.Cond = v_cond;
  assign ifa.ALUFlags = v_aluflags; assign ifb.ALUFlags = v_aluflags;

  cond_unit_pipe #(.REG_OUT(1'b0), .CNT_W(4), .FLAG_RST(4'b0000)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .cnt_clr(cnt_clr),
    .instr_cnt(icnt_a), .fail_cnt(fcnt_a)
  );

  cond_unit_pipe #(.REG_OUT(1'b1), .CNT_W(16), .FLAG_RST(4'b0000)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .cnt_clr(cnt_clr),
    .instr_cnt(icnt_b), .fail_cnt(fcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_valid = 0; v_stall = 0; v_flush = 0; v_pcs = 0; v_regw = 0; v_memw = 0;
    v_nowrite = 0; v_flagw = 2'b00; v_cond = 4'd14; v_aluflags = 4'b0000;
  endtask

  task automatic instr(input logic [3:0] cond, input logic [1:0] flagw, input logic [3:0] alu,
                       input logic pcs, input logic regw, input logic memw, input logic nowrite);
    v_valid = 1; v_stall = 0; v_flush = 0; v_cond = cond; v_flagw = flagw; v_aluflags = alu;
    v_pcs = pcs; v_regw = regw; v_memw = memw; v_nowrite = nowrite;
  endtask

  task automatic test_reset();
    reset = 1; cnt_clr = 0;
    instr(4'd14, 2'b11, 4'b1111, 1, 1, 1, 0);
    tick(); tick();
    n_chk++; if (ifa.Flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got=%b exp=0000", ifa.Flags); end
    n_chk++; if (icnt_a !== 4'd0 || fcnt_a !== 4'd0) begin n_fail++; $display("FAIL rst_cnt_a got=%0d/%0d exp=0/0", icnt_a, fcnt_a); end
    n_chk++; if (icnt_b !== 16'd0) begin n_fail++; $display("FAIL rst_cnt_b got=%0d exp=0", icnt_b); end
    n_chk++; if ({ifb.PCSrc, ifb.RegWrite, ifb.MemWrite} !== 3'b000) begin n_fail++; $display("FAIL rst_regout got=%b exp=000", {ifb.PCSrc, ifb.RegWrite, ifb.MemWrite}); end
    reset = 0;
    idle();
    tick();
  endtask

  task automatic test_basic();
    instr(4'd14, 2'b00, 4'b1111, 0, 1, 0, 0);
    #1;
    n_chk++; if (ifa.RegWrite !== 1'b1) begin n_fail++; $display("FAIL t1_regwrite_a got=%b exp=1", ifa.RegWrite); end
    tick();
    idle();
    n_chk++; if (ifb.RegWrite !== 1'b1) begin n_fail++; $display("FAIL t1_regwrite_b got=%b exp=1", ifb.RegWrite); end
    n_chk++; if (ifa.Flags !== 4'b0000) begin n_fail++; $display("FAIL t1_flags got=%b exp=0000", ifa.Flags); end
    n_chk++; if (icnt_a !== 4'd1) begin n_fail++; $display("FAIL t1_icnt got=%0d exp=1", icnt_a); end
    #1;
    n_chk++; if (ifa.RegWrite !== 1'b0) begin n_fail++; $display("FAIL t1_idle_regwrite got=%b exp=0", ifa.RegWrite); end
  endtask

  task automatic test_back_to_back();
    instr(4'd1, 2'b11, 4'b1000, 0, 1, 0, 0);
    #1;
    n_chk++; if (ifa.RegWrite !== 1'b1) begin n_fail++; $display("FAIL t2_ne_regwrite got=%b exp=1", ifa.RegWrite); end
    tick();
    n_chk++; if (ifa.Flags !== 4'b1000) begin n_fail++; $display("FAIL t2_flags_upd got=%b exp=1000", ifa.Flags); end
    instr(4'd0, 2'b11, 4'b0111, 0, 1, 0, 0);
    #1;
    n_chk++; if (ifa.CondEx !== 1'b0 || ifa.RegWrite !== 1'b0) begin n_fail++; $display("FAIL t2_eq_fail got=%b%b exp=00", ifa.CondEx, ifa.RegWrite); end
    tick();
    idle();
    n_chk++; if (ifa.Flags !== 4'b1000) begin n_fail++; $display("FAIL t2_flags_hold got=%b exp=1000", ifa.Flags); end
    n_chk++; if (fcnt_a !== 4'd1 || icnt_a !== 4'd3) begin n_fail++; $display("FAIL t2_cnt got=%0d/%0d exp=3/1", icnt_a, fcnt_a); end
    n_chk++; if (ifb.RegWrite !== 1'b0) begin n_fail++; $display("FAIL t2_regwrite_b got=%b exp=0", ifb.RegWrite); end
  endtask

  task automatic test_nowrite();
    instr(4'd14, 2'b11, 4'b0100, 0, 1, 0, 1);
    #1;
    n_chk++; if (ifa.RegWrite !== 1'b0 || ifa.CondEx !== 1'b1) begin n_fail++; $display("FAIL t3_cmp got=%b%b exp=10", ifa.CondEx, ifa.RegWrite); end
    tick();
    n_chk++; if (ifa.Flags !== 4'b0100) begin n_fail++; $display("FAIL t3_cmp_flags got=%b exp=0100", ifa.Flags); end
    n_chk++; if (ifb.RegWrite !== 1'b0) begin n_fail++; $display("FAIL t3_cmp_regwrite_b got=%b exp=0", ifb.RegWrite); end
    instr(4'd0, 2'b00, 4'b0000, 1, 0, 1, 0);
    #1;
    n_chk++; if (ifa.PCSrc !== 1'b1 || ifa.MemWrite !== 1'b1) begin n_fail++; $display("FAIL t3_beq got=%b%b exp=11", ifa.PCSrc, ifa.MemWrite); end
    tick();
    idle();
    n_chk++; if (ifb.PCSrc !== 1'b1 || ifb.MemWrite !== 1'b1) begin n_fail++; $display("FAIL t3_beq_b got=%b%b exp=11", ifb.PCSrc, ifb.MemWrite); end
    n_chk++; if (icnt_a !== 4'd5) begin n_fail++; $display("FAIL t3_icnt got=%0d exp=5", icnt_a); end
  endtask

  task automatic test_stall_flush();
    for (int k = 0; k < 3; k++) begin
      instr(4'd14, 2'b11, 4'b1011, 1, 1, 1, 0);
      v_stall = (k != 1);
      v_flush = (k != 0);
      #1;
      n_chk++; if ({ifa.PCSrc, ifa.RegWrite, ifa.MemWrite} !== 3'b000) begin n_fail++; $display("FAIL t4_writes_%0d got=%b exp=000", k, {ifa.PCSrc, ifa.RegWrite, ifa.MemWrite}); end
      tick();
      n_chk++; if (ifa.Flags !== 4'b0100 || icnt_a !== 4'd5 || fcnt_a !== 4'd1) begin n_fail++; $display("FAIL t4_hold_%0d got=%b/%0d/%0d exp=0100/5/1", k, ifa.Flags, icnt_a, fcnt_a); end
      n_chk++; if ({ifb.PCSrc, ifb.RegWrite, ifb.MemWrite} !== 3'b000) begin n_fail++; $display("FAIL t4_writes_b_%0d got=%b exp=000", k, {ifb.PCSrc, ifb.RegWrite, ifb.MemWrite}); end
    end
    idle();
  endtask

  task automatic test_flags_cond();
    bit exp_t [16];
    bit exp_u [16];
    instr(4'd14, 2'b11, 4'b0000, 0, 0, 0, 0);
    tick();
    instr(4'd14, 2'b01, 4'b1111, 0, 0, 0, 0);
    tick();
    n_chk++; if (ifa.Flags !== 4'b0011 || ifa.CarryIn !== 1'b1) begin n_fail++; $display("FAIL t5_flagw01 got=%b c=%b exp=0011 c=1", ifa.Flags, ifa.CarryIn); end
    instr(4'd15, 2'b11, 4'b1100, 1, 1, 1, 0);
    #1;
    n_chk++; if (ifa.CondEx !== 1'b0 || ifa.RegWrite !== 1'b0) begin n_fail++; $display("FAIL t5_nv got=%b%b exp=00", ifa.CondEx, ifa.RegWrite); end
    tick();
    n_chk++; if (ifa.Flags !== 4'b0011 || fcnt_a !== 4'd2 || icnt_a !== 4'd8) begin n_fail++; $display("FAIL t5_nv_state got=%b/%0d/%0d exp=0011/8/2", ifa.Flags, icnt_a, fcnt_a); end
    idle();
    // Flags = N0 Z0 C1 V1
    exp_t = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      v_cond = i[3:0];
      #1;
      n_chk++; if (ifa.CondEx !== exp_t[i]) begin n_fail++; $display("FAIL t5_cond0011_%0d got=%b exp=%b", i, ifa.CondEx, exp_t[i]); end
    end
    instr(4'd14, 2'b11, 4'b1101, 0, 0, 0, 0);
    tick();
    idle();
    // Flags = N1 Z1 C0 V1
    exp_u = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      v_cond = i[3:0];
      #1;
      n_chk++; if (ifa.CondEx !== exp_u[i]) begin n_fail++; $display("FAIL t5_cond1101_%0d got=%b exp=%b", i, ifa.CondEx, exp_u[i]); end
    end
  endtask

  task automatic test_counters_reset();
    instr(4'd14, 2'b00, 4'b0000, 0, 0, 0, 0);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    n_chk++; if (icnt_a !== 4'd0 || icnt_b !== 16'd0 || fcnt_b !== 16'd0) begin n_fail++; $display("FAIL t6_clr got=%0d/%0d/%0d exp=0/0/0", icnt_a, icnt_b, fcnt_b); end
    n_chk++; if (ifa.Flags !== 4'b1101) begin n_fail++; $display("FAIL t6_clr_flags got=%b exp=1101", ifa.Flags); end
    instr(4'd15, 2'b11, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) tick();
    n_chk++; if (icnt_a !== 4'd15 || fcnt_a !== 4'd15) begin n_fail++; $display("FAIL t6_sat_a got=%0d/%0d exp=15/15", icnt_a, fcnt_a); end
    n_chk++; if (icnt_b !== 16'd17 || fcnt_b !== 16'd17) begin n_fail++; $display("FAIL t6_cnt_b got=%0d/%0d exp=17/17", icnt_b, fcnt_b); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    n_chk++; if (icnt_a !== 4'd0 || fcnt_a !== 4'd0) begin n_fail++; $display("FAIL t6_clr_go got=%0d/%0d exp=0/0", icnt_a, fcnt_a); end
    instr(4'd14, 2'b00, 4'b0000, 0, 0, 0, 0);
    tick(); tick();
    instr(4'd14, 2'b11, 4'b0110, 1, 1, 1, 0);
    reset = 1;
    tick();
    reset = 0;
    idle();
    n_chk++; if (ifa.Flags !== 4'b0000 || icnt_a !== 4'd0 || icnt_b !== 16'd0) begin n_fail++; $display("FAIL t6_midrst got=%b/%0d/%0d exp=0000/0/0", ifa.Flags, icnt_a, icnt_b); end
    n_chk++; if ({ifb.PCSrc, ifb.RegWrite, ifb.MemWrite} !== 3'b000) begin n_fail++; $display("FAIL t6_midrst_b got=%b exp=000", {ifb.PCSrc, ifb.RegWrite, ifb.MemWrite}); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1;
    cnt_clr = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_nowrite();
    test_stall_flush();
    test_flags_cond();
    test_counters_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
